// File: rtl/drv_chk_1r1wor2w_1rw.sv
// drv_chk_1r1wor2w_1rw
// Pseudo-random traffic initiator and read checker for the virtual port of a 1r1w-or-2w
// algorithmic memory. Each RUN cycle issues either one read plus one write (both on port 0)
// or two writes. One address (select_addr) is shadowed. Every read is checked for a
// matching rd_vld at READ_LAT, and reads of the shadowed address are also checked for data.
// Optional build macro: DRV_CHK_IDLE_INS_EN inserts LFSR-driven idle cycles while running.
module drv_chk_1r1wor2w_1rw #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUMADDR  = 8192,
  parameter int unsigned BITADDR  = 13,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned NUMTXN   = 1024,
  parameter int unsigned BITTXN   = 16,
  parameter logic [31:0] SEED     = 32'hACE1_2B3D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ready,
  input  logic [BITADDR-1:0]   select_addr,
  output logic                 read,
  output logic [1:0]           write,
  output logic [2*BITADDR-1:0] addr,
  output logic [2*WIDTH-1:0]   din,
  input  logic                 rd_vld,
  input  logic [WIDTH-1:0]     rd_dout,
  input  logic                 rd_err,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [BITTXN-1:0]    err_cnt,
  output logic [BITTXN-1:0]    txn_cnt
);

  // Galois feedback mask for taps 32,22,2,1 (right-shifting form).
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;
  localparam int unsigned DrainW  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic             rd;
    logic             sel;
    logic             shadow_vld;
    logic [WIDTH-1:0] expected;
  } pipe_t;

  state_e              state_q, state_d;
  logic [31:0]         lfsr_q, lfsr_d, lfsr_next;
  logic [BITTXN-1:0]   txn_cnt_q, txn_cnt_d;
  logic [BITTXN-1:0]   err_cnt_q, err_cnt_d;
  logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [WIDTH-1:0]    shadow_q, shadow_d;
  logic                shadow_vld_q, shadow_vld_d;
  pipe_t               pipe_q [READ_LAT];
  pipe_t               pipe_in, pipe_out;

  logic                idle_slot, issue, mode_2w;
  logic [BITADDR-1:0]  addr0, addr1, addr1_raw, addr1_alt;
  logic [31:0]         word0, word1;
  logic [WIDTH-1:0]    data0, data1;
  logic                wr0_sel, wr1_sel;
  logic                vld_err, data_err, flag_err, mismatch;

  // Out-of-range raw addresses are pulled back into range by dropping their MSB.
  function automatic logic [BITADDR-1:0] fold_addr(input logic [BITADDR-1:0] a);
    logic [BITADDR-1:0] r;
    r = a;
    if (32'(a) >= NUMADDR) r[BITADDR-1] = 1'b0;
    return r;
  endfunction

  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
  assign mode_2w   = lfsr_q[0];

`ifdef DRV_CHK_IDLE_INS_EN
  assign idle_slot = (lfsr_q[7:5] == 3'b000);
`else
  assign idle_slot = 1'b0;
`endif

  assign issue = (state_q == StRun) && ready && !idle_slot;

  // Port addresses; port 1 is nudged off port 0 so the two writes never collide.
  always_comb begin
    addr0     = (lfsr_q[3:2] == 2'b00) ? select_addr : fold_addr(lfsr_q[4 +: BITADDR]);
    addr1_raw = fold_addr(lfsr_q[31 -: BITADDR]);
    addr1_alt = addr1_raw ^ BITADDR'(1);
    if (32'(addr1_alt) >= NUMADDR) addr1_alt = addr1_raw ^ BITADDR'(2);
    addr1     = (addr1_raw == addr0) ? addr1_alt : addr1_raw;
  end

  // Write data: LFSR state salted with the transaction number and port index.
  always_comb begin
    word0 = lfsr_q ^ 32'({txn_cnt_q, 1'b0});
    word1 = lfsr_q ^ 32'({txn_cnt_q, 1'b1});
    data0 = '0;
    data1 = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      data0[i] = word0[i % 32];
      data1[i] = word1[i % 32];
    end
  end

  // Memory-side request outputs; everything is zero on non-issue cycles.
  always_comb begin
    read  = 1'b0;
    write = 2'b00;
    addr  = '0;
    din   = '0;
    if (issue) begin
      read                  = !mode_2w;
      write                 = {mode_2w, 1'b1};
      addr[BITADDR-1:0]     = addr0;
      din[WIDTH-1:0]        = data0;
      if (mode_2w) begin
        addr[2*BITADDR-1:BITADDR] = addr1;
        din[2*WIDTH-1:WIDTH]      = data1;
      end
    end
  end

  // Shadow copy of select_addr; a same-cycle read still sees the old value.
  always_comb begin
    wr0_sel      = write[0] && (addr0 == select_addr);
    wr1_sel      = write[1] && (addr1 == select_addr);
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    if (wr1_sel) begin
      shadow_d     = data1;
      shadow_vld_d = 1'b1;
    end else if (wr0_sel) begin
      shadow_d     = data0;
      shadow_vld_d = 1'b1;
    end
  end

  // Entry for the expect pipe and the comparison at the read-return stage.
  always_comb begin
    pipe_in.rd         = read;
    pipe_in.sel        = read && (addr0 == select_addr);
    pipe_in.shadow_vld = shadow_vld_q;
    pipe_in.expected   = shadow_q;
    pipe_out           = pipe_q[READ_LAT-1];
    vld_err            = pipe_out.rd ^ rd_vld;
    flag_err           = rd_vld && rd_err;
    data_err           = rd_vld && !rd_err && pipe_out.rd && pipe_out.sel &&
                         pipe_out.shadow_vld && (rd_dout != pipe_out.expected);
    mismatch           = vld_err || flag_err || data_err;
  end

  // Run sequencing: wait for ready, issue NUMTXN cycles, drain READ_LAT cycles.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    lfsr_d      = (state_q == StRun) ? lfsr_next : lfsr_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StWaitRdy;
      end
      StWaitRdy: begin
        if (ready) state_d = StRun;
      end
      StRun: begin
        drain_cnt_d = '0;
        if (issue && (txn_cnt_q == BITTXN'(NUMTXN - 1))) state_d = StDrain;
      end
      StDrain: begin
        drain_cnt_d = drain_cnt_q + DrainW'(1);
        if (drain_cnt_q == DrainW'(READ_LAT - 1)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Run status; a start in IDLE clears everything from the previous run.
  always_comb begin
    txn_cnt_d = txn_cnt_q;
    err_cnt_d = err_cnt_q;
    done_d    = done_q;
    fail_d    = fail_q;
    if (issue) txn_cnt_d = txn_cnt_q + BITTXN'(1);
    if ((state_q == StDrain) && (state_d == StDone)) done_d = 1'b1;
    if (mismatch) begin
      fail_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + BITTXN'(1);
    end
    if ((state_q == StIdle) && start) begin
      txn_cnt_d = '0;
      err_cnt_d = '0;
      done_d    = 1'b0;
      fail_d    = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      lfsr_q       <= SEED;
      txn_cnt_q    <= '0;
      err_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      for (int i = 0; i < int'(READ_LAT); i++) pipe_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      txn_cnt_q    <= txn_cnt_d;
      err_cnt_q    <= err_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      pipe_q[0]    <= pipe_in;
      for (int i = 1; i < int'(READ_LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign busy    = (state_q == StWaitRdy) || (state_q == StRun) || (state_q == StDrain);
  assign done    = done_q;
  assign fail    = fail_q;
  assign err_cnt = err_cnt_q;
  assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_drv_chk_1r1wor2w_1rw.sv
// Bench for drv_chk_1r1wor2w_1rw: a behavioural memory answers the main instance, end-of-run
// expectations go through a scoreboard queue, and a second instance with a crafted seed
// exercises the port-1 address collision rule on its first issue cycle.
module tb_drv_chk_1r1wor2w_1rw;

  localparam int unsigned W     = 32;
  localparam int unsigned BA    = 13;
  localparam int unsigned NT    = 16;
  localparam int unsigned RL    = 2;
  localparam logic [BA-1:0] SEL = 13'd5;
  // bit0=1 (2w), bits[3:2]=01, bits[16:4]=7, bits[31:19]=7
  localparam logic [31:0] SEEDC = 32'h0038_0075;

  localparam int MIdeal   = 0;
  localparam int MCorrupt = 1;
  localparam int MDelay   = 2;
  localparam int MErrFlag = 3;

  typedef struct {
    int mode;
    int cbase;
    int rbase;
  } exp_t;

  logic clk, rst;
  logic start_m, ready_m;
  logic read_m, busy_m, done_m, fail_m;
  logic [1:0] write_m;
  logic [2*BA-1:0] addr_m;
  logic [2*W-1:0] din_m;
  logic rd_vld_m, rd_err_m;
  logic [W-1:0] rd_dout_m;
  logic [15:0] err_cnt_m, txn_cnt_m;

  logic start_c, ready_c;
  logic read_c, busy_c, done_c, fail_c;
  logic [1:0] write_c;
  logic [2*BA-1:0] addr_c;
  logic [2*W-1:0] din_c;
  logic rd_vld_c, rd_err_c;
  logic [W-1:0] rd_dout_c;
  logic [15:0] err_cnt_c, txn_cnt_c;

  int checks = 0;
  int failures = 0;
  int mode = MIdeal;
  int corrupt_total = 0;
  int read_total = 0;
  int sb_seen = 0;
  int sb_target = 0;
  exp_t sbq[$];

  logic [31:0] mem [int];
  logic [2:0]  pv;
  logic [W-1:0] pd0, pd1, pd2;

  drv_chk_1r1wor2w_1rw #(
    .WIDTH(W), .NUMADDR(8192), .BITADDR(BA), .READ_LAT(RL), .NUMTXN(NT), .BITTXN(16),
    .SEED(32'hACE1_2B3D)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start_m), .ready(ready_m), .select_addr(SEL),
    .read(read_m), .write(write_m), .addr(addr_m), .din(din_m),
    .rd_vld(rd_vld_m), .rd_dout(rd_dout_m), .rd_err(rd_err_m),
    .busy(busy_m), .done(done_m), .fail(fail_m), .err_cnt(err_cnt_m), .txn_cnt(txn_cnt_m)
  );

  drv_chk_1r1wor2w_1rw #(
    .WIDTH(W), .NUMADDR(8192), .BITADDR(BA), .READ_LAT(RL), .NUMTXN(NT), .BITTXN(16),
    .SEED(SEEDC)
  ) u_col (
    .clk(clk), .rst(rst), .start(start_c), .ready(ready_c), .select_addr(SEL),
    .read(read_c), .write(write_c), .addr(addr_c), .din(din_c),
    .rd_vld(rd_vld_c), .rd_dout(rd_dout_c), .rd_err(rd_err_c),
    .busy(busy_c), .done(done_c), .fail(fail_c), .err_cnt(err_cnt_c), .txn_cnt(txn_cnt_c)
  );

  assign rd_vld_c  = 1'b0;
  assign rd_dout_c = '0;
  assign rd_err_c  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory model: read-before-write, data returned after RL (or RL+1 in delay mode).
  initial begin : mem_model
    int m_a;
    logic [31:0] m_rdat;
    forever begin
      @(posedge clk);
      if (rst) begin
        pv  <= '0;
        pd0 <= '0;
        pd1 <= '0;
        pd2 <= '0;
        mem.delete();
      end else begin
        m_rdat = '0;
        if (read_m) begin
          m_a = int'(addr_m[BA-1:0]);
          if (mem.exists(m_a)) m_rdat = mem[m_a];
          if (mode == MCorrupt && m_a == int'(SEL) && mem.exists(m_a)) begin
            m_rdat[0] = ~m_rdat[0];
            corrupt_total++;
          end
          read_total++;
        end
        if (write_m[0]) mem[int'(addr_m[BA-1:0])] = din_m[W-1:0];
        if (write_m[1]) mem[int'(addr_m[2*BA-1:BA])] = din_m[2*W-1:W];
        pv  <= {pv[1:0], read_m};
        pd0 <= m_rdat;
        pd1 <= pd0;
        pd2 <= pd1;
      end
    end
  end

  assign rd_vld_m  = (mode == MDelay) ? pv[2] : pv[1];
  assign rd_dout_m = (mode == MDelay) ? pd2 : pd1;
  assign rd_err_m  = (mode == MErrFlag) && rd_vld_m;

  // Scoreboard monitor: on each completed run, compare status against the queued expectation.
  initial begin : monitor
    exp_t e;
    int n;
    forever begin
      @(posedge done_m);
      repeat (3) @(negedge clk);
      if (sbq.size() == 0) begin
        chk("scoreboard underflow", 64'(sbq.size()), 1);
      end else begin
        e = sbq.pop_front();
        chk("run done", done_m, 1);
        chk("run txn_cnt", txn_cnt_m, NT);
        case (e.mode)
          MIdeal: begin
            chk("ideal fail", fail_m, 0);
            chk("ideal err_cnt", err_cnt_m, 0);
          end
          MCorrupt: begin
            n = corrupt_total - e.cbase;
            chk("corrupt err_cnt", err_cnt_m, n);
            chk("corrupt fail", fail_m, n != 0);
          end
          MDelay: begin
            chk("delay fail", fail_m, 1);
            chk("delay err_cnt>=2", err_cnt_m >= 16'd2, 1);
          end
          default: begin
            n = read_total - e.rbase;
            chk("rd_err err_cnt", err_cnt_m, n);
            chk("rd_err fail", fail_m, n != 0);
          end
        endcase
      end
      sb_seen++;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
  endtask

  task automatic start_run(input int m);
    exp_t e;
    mode    = m;
    e.mode  = m;
    e.cbase = corrupt_total;
    e.rbase = read_total;
    sbq.push_back(e);
    sb_target++;
    pulse_start();
  endtask

  // Waits (bounded) for done, then for the monitor to finish with this run.
  task automatic wait_end(output int lat);
    int n;
    lat = 0;
    while (!done_m && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("done reached", done_m, 1);
    n = 0;
    while (sb_seen != sb_target && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard drained", sb_seen, sb_target);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " read"}, read_m, 0);
    chk({tag, " write"}, write_m, 0);
    chk({tag, " addr"}, addr_m, 0);
    chk({tag, " din"}, din_m, 0);
    chk({tag, " busy"}, busy_m, 0);
    chk({tag, " done"}, done_m, 0);
    chk({tag, " fail"}, fail_m, 0);
    chk({tag, " err_cnt"}, err_cnt_m, 0);
    chk({tag, " txn_cnt"}, txn_cnt_m, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    int n;
    int cbase;
    rst = 1'b1;
    start_m = 1'b0;
    ready_m = 1'b0;
    start_c = 1'b0;
    ready_c = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Collision: both raw addresses are 7 in 2w mode, so port 1 becomes 6.
    @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    @(negedge clk);
    chk("col write", write_c, 2'b11);
    chk("col read", read_c, 0);
    chk("col addr", addr_c, {13'd6, 13'd7});
    chk("col din", din_c, {SEEDC ^ 32'h1, SEEDC});
    chk("col busy", busy_c, 1);
    chk("col done", done_c, 0);
    chk("col fail", fail_c, 0);
    chk("col err_cnt", err_cnt_c, 0);
    chk("col txn_cnt", txn_cnt_c, 0);

    // Run 1: ready low for 5 cycles after start, then a ready drop mid-run.
    start_run(MIdeal);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("wait_rdy read", read_m, 0);
      chk("wait_rdy write", write_m, 0);
      chk("wait_rdy busy", busy_m, 1);
      chk("wait_rdy txn_cnt", txn_cnt_m, 0);
    end
    ready_m = 1'b1;
    #1;
    chk("no issue in ready cycle", write_m, 0);
    @(negedge clk);
    chk("first issue", write_m != 2'b00, 1);
    chk("first issue txn_cnt", txn_cnt_m, 0);
    @(negedge clk);
    chk("second issue txn_cnt", txn_cnt_m, 1);
    @(negedge clk);
    ready_m = 1'b0;
    #1;
    chk("stall write", write_m, 0);
    chk("stall read", read_m, 0);
    @(negedge clk);
    chk("stall txn_cnt held", txn_cnt_m, 2);
    chk("stall busy", busy_m, 1);
    ready_m = 1'b1;
    wait_end(lat);

    // Run 2: ideal memory, ready always high; done one wait cycle + issues + drain later.
    start_run(MIdeal);
    wait_end(lat);
    chk("run latency", lat, NT + RL + 1);

    // Corrupted reads of the shadowed address; repeat until at least one is hit.
    for (int k = 0; k < 8; k++) begin
      cbase = corrupt_total;
      start_run(MCorrupt);
      wait_end(lat);
      if (corrupt_total != cbase) break;
    end

    start_run(MDelay);
    wait_end(lat);

    start_run(MErrFlag);
    wait_end(lat);

    // Reset in the middle of a run, then a complete run.
    mode = MIdeal;
    pulse_start();
    n = 0;
    while (txn_cnt_m != 16'd9 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached txn 9", txn_cnt_m, 9);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrun reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("no partial done", done_m, 0);
    chk("idle after reset busy", busy_m, 0);
    start_run(MIdeal);
    wait_end(lat);
    chk("post-reset latency", lat, NT + RL + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
